// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch-stage types, widths and reset defaults.
// Width constants are meant for reuse by decode/control.
package if_stage_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] PC_RESET_DEF = 32'h0000_0000;
   localparam logic [ILEN-1:0] NOP_WORD_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } if_state_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: {ins, pc4, valid} pipeline register; flush beats hold, hold beats load.
// Reset and flush both leave a NOP bubble with pc4 cleared.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter int              IW  = ILEN,
   parameter int              AW  = XLEN,
   parameter logic [IW-1:0]   NOP = NOP_WORD_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          flush,
   input  logic          hold,
   input  logic [IW-1:0] ins_next,
   input  logic [AW-1:0] pc4_next,
   input  logic          valid_next,
   output logic [IW-1:0] ins,
   output logic [AW-1:0] pc4,
   output logic          valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ins   <= NOP;
         pc4   <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         ins   <= NOP;
         pc4   <= '0;
         valid <= 1'b0;
      end else if (load && !hold) begin
         ins   <= ins_next;
         pc4   <= pc4_next;
         valid <= valid_next;
      end
   end

endmodule

// File: rtl/if_stage.sv
// if_stage: PC, single-outstanding imem fetch FSM and IF/ID register.
// Optional build macro IF_PERFCNT_EN adds saturating fetch/bubble counters.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] PC_RESET = PC_RESET_DEF,
   parameter logic [ILEN-1:0] NOP_WORD = NOP_WORD_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [ILEN-1:0] imem_rdata,
   output logic [ILEN-1:0] id_ins,
   output logic [XLEN-1:0] id_pc4,
`ifdef IF_PERFCNT_EN
   output logic            id_valid,
   output logic [31:0]     perf_fetch_cnt,
   output logic [31:0]     perf_bubble_cnt
`else
   output logic            id_valid
`endif
);

   if_state_t       state;
   logic [XLEN-1:0] pc, req_addr, target, pc_inc, fetch_pc4, buf_pc4, ld_pc4;
   logic [ILEN-1:0] buf_ins, ld_ins;
   logic            in_fetch, in_hold, in_drain, flush, load;

   assign in_fetch  = state == FETCH;
   assign in_hold   = state == HOLD;
   assign in_drain  = state == DRAIN;
   assign target    = word_align(redirect_pc);
   assign pc_inc    = pc + XLEN'(4);
   assign fetch_pc4 = req_addr + XLEN'(4);

   // Reset gates the request combinationally so nothing is asked for while rst_n is low.
   assign imem_req  = rst_n & (in_fetch | in_drain);
   assign imem_addr = req_addr;

   assign flush  = redirect & (in_fetch | in_hold | in_drain)
                 | !stall & (in_fetch & !imem_ack | in_drain);
   assign load   = in_fetch & imem_ack | in_hold;
   assign ld_ins = in_hold ? buf_ins : imem_rdata;
   assign ld_pc4 = in_hold ? buf_pc4 : fetch_pc4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         pc       <= PC_RESET;
         req_addr <= PC_RESET;
         buf_ins  <= NOP_WORD;
         buf_pc4  <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (redirect) begin
                  pc <= target;
                  // A same-cycle ack is dropped; otherwise the old request must drain first.
                  if (imem_ack) req_addr <= target;
                  else          state    <= DRAIN;
               end else if (imem_ack) begin
                  pc       <= pc_inc;
                  req_addr <= pc_inc;
                  if (stall) begin
                     state   <= HOLD;
                     buf_ins <= imem_rdata;
                     buf_pc4 <= fetch_pc4;
                  end
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc       <= target;
                  req_addr <= target;
                  state    <= FETCH;
               end else if (!stall) begin
                  state <= FETCH;
               end
            end
            DRAIN: begin
               if (redirect) pc <= target;
               if (imem_ack) begin
                  req_addr <= redirect ? target : pc;
                  state    <= FETCH;
               end
            end
            default: begin
               state    <= FETCH;
               req_addr <= pc;
            end
         endcase
      end
   end

   if_id_reg #(.IW(ILEN), .AW(XLEN), .NOP(NOP_WORD)) u_if_id (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .flush      (flush),
      .hold       (stall),
      .ins_next   (ld_ins),
      .pc4_next   (ld_pc4),
      .valid_next (1'b1),
      .ins        (id_ins),
      .pc4        (id_pc4),
      .valid      (id_valid)
   );

`ifdef IF_PERFCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt  <= '0;
         perf_bubble_cnt <= '0;
      end else begin
         if (flush && perf_bubble_cnt != '1) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
         if (!flush && load && !stall && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test-plan scenarios plus a randomized run against a transaction-level model.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
   logic [31:0] redirect_pc = '0, imem_rdata = '0;
   logic        imem_req, id_valid;
   logic [31:0] imem_addr, id_ins, id_pc4;
`ifdef IF_PERFCNT_EN
   logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .id_ins          (id_ins),
      .id_pc4          (id_pc4),
`ifdef IF_PERFCNT_EN
      .id_valid        (id_valid),
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_bubble_cnt (perf_bubble_cnt)
`else
      .id_valid        (id_valid)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   // Model: a pending fetch address, a flag marking it as to-be-discarded,
   // and a one-deep queue of fetched-but-not-yet-delivered instructions.
   typedef struct packed {logic [31:0] ins; logic [31:0] pc4;} ent_t;
   ent_t        m_q[$];
   logic [31:0] m_pc, m_addr, m_ins, m_pc4;
   logic        m_drop, m_valid;
   int unsigned m_fetch_n, m_bubble_n;

   task automatic model_reset();
      m_q.delete();
      m_pc = 0; m_addr = 0; m_drop = 0;
      m_ins = 0; m_pc4 = 0; m_valid = 0;
      m_fetch_n = 0; m_bubble_n = 0;
   endtask

   task automatic model_bubble();
      m_ins = 0; m_pc4 = 0; m_valid = 0;
      m_bubble_n++;
   endtask

   task automatic model_tick();
      logic [31:0] tgt;
      ent_t e;
      tgt = {redirect_pc[31:2], 2'b00};
      if (m_q.size() != 0) begin
         if (redirect) begin
            m_q.delete(); m_pc = tgt; m_addr = tgt; model_bubble();
         end else if (!stall) begin
            e = m_q.pop_front();
            m_ins = e.ins; m_pc4 = e.pc4; m_valid = 1; m_fetch_n++;
         end
      end else if (m_drop) begin
         if (redirect) m_pc = tgt;
         if (redirect || !stall) model_bubble();
         if (imem_ack) begin m_drop = 0; m_addr = m_pc; end
      end else if (redirect) begin
         m_pc = tgt; model_bubble();
         if (imem_ack) m_addr = m_pc; else m_drop = 1;
      end else if (imem_ack) begin
         e.ins = mem_word(m_addr); e.pc4 = m_addr + 4;
         m_pc = m_pc + 4; m_addr = m_pc;
         if (stall) m_q.push_back(e);
         else begin m_ins = e.ins; m_pc4 = e.pc4; m_valid = 1; m_fetch_n++; end
      end else if (!stall) begin
         model_bubble();
      end
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cyc(input logic s, input logic r, input logic [31:0] rp, input logic a);
      stall = s; redirect = r; redirect_pc = rp;
      imem_ack = a & imem_req;
      imem_rdata = mem_word(imem_addr);
      @(posedge clk);
      model_tick();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; stall = 0; redirect = 0; imem_ack = 0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks += 4;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", imem_req); end
      if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", id_valid); end
      if (id_ins !== 32'h0) begin n_fail++; $display("FAIL rst_ins got %h want 0", id_ins); end
      if (id_pc4 !== 32'h0) begin n_fail++; $display("FAIL rst_pc4 got %h want 0", id_pc4); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      n_checks += 2;
      if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_first_req got %b want 1", imem_req); end
      if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_first_addr got %h want 0", imem_addr); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL b2b_addr[%0d] got %h want %h", i, imem_addr, 32'(4 * i)); end
         cyc(0, 0, 0, 1);
         n_checks += 3;
         if (id_pc4 !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL b2b_pc4[%0d] got %h want %h", i, id_pc4, 32'(4 * i + 4)); end
         if (id_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b want 1", i, id_valid); end
         if (id_ins !== mem_word(32'(4 * i))) begin n_fail++; $display("FAIL b2b_ins[%0d] got %h want %h", i, id_ins, mem_word(32'(4 * i))); end
      end
   endtask

   task automatic test_wait_states();
      apply_reset();
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 2; i++) begin
         cyc(0, 0, 0, 0);
         n_checks += 3;
         if (id_valid !== 1'b0) begin n_fail++; $display("FAIL ws_bubble[%0d] got %b want 0", i, id_valid); end
         if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL ws_addr[%0d] got %h want 8", i, imem_addr); end
         if (imem_req !== 1'b1) begin n_fail++; $display("FAIL ws_req[%0d] got %b want 1", i, imem_req); end
      end
      cyc(0, 0, 0, 1);
      n_checks += 3;
      if (id_ins !== mem_word(32'h8)) begin n_fail++; $display("FAIL ws_ins got %h want %h", id_ins, mem_word(32'h8)); end
      if (id_pc4 !== 32'hC) begin n_fail++; $display("FAIL ws_pc4 got %h want c", id_pc4); end
      if (id_valid !== 1'b1) begin n_fail++; $display("FAIL ws_valid got %b want 1", id_valid); end
   endtask

   task automatic test_stall_hold();
      apply_reset();
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, i == 0);
         n_checks += 3;
         if (id_pc4 !== 32'h10) begin n_fail++; $display("FAIL st_hold_pc4[%0d] got %h want 10", i, id_pc4); end
         if (id_valid !== 1'b1) begin n_fail++; $display("FAIL st_hold_valid[%0d] got %b want 1", i, id_valid); end
         if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_hold_req[%0d] got %b want 0", i, imem_req); end
      end
      cyc(0, 0, 0, 0);
      n_checks += 4;
      if (id_pc4 !== 32'h14) begin n_fail++; $display("FAIL st_rel_pc4 got %h want 14", id_pc4); end
      if (id_ins !== mem_word(32'h10)) begin n_fail++; $display("FAIL st_rel_ins got %h want %h", id_ins, mem_word(32'h10)); end
      if (imem_req !== 1'b1) begin n_fail++; $display("FAIL st_rel_req got %b want 1", imem_req); end
      if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL st_rel_addr got %h want 14", imem_addr); end
   endtask

   task automatic test_redirect_drain();
      apply_reset();
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
      cyc(0, 1, 32'h40, 0);
      n_checks += 2;
      if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rd_flush got %b want 0", id_valid); end
      if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL rd_addr_hold got %h want 20", imem_addr); end
      cyc(0, 0, 0, 0);
      n_checks += 2;
      if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL rd_addr_hold2 got %h want 20", imem_addr); end
      if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rd_req got %b want 1", imem_req); end
      cyc(0, 0, 0, 1);
      n_checks += 2;
      if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rd_drop got %b want 0", id_valid); end
      if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL rd_new_addr got %h want 40", imem_addr); end
      cyc(0, 0, 0, 1);
      n_checks += 3;
      if (id_pc4 !== 32'h44) begin n_fail++; $display("FAIL rd_pc4 got %h want 44", id_pc4); end
      if (id_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid got %b want 1", id_valid); end
      if (id_ins !== mem_word(32'h40)) begin n_fail++; $display("FAIL rd_ins got %h want %h", id_ins, mem_word(32'h40)); end
   endtask

   task automatic test_redirect_in_hold();
      apply_reset();
      cyc(1, 0, 0, 1);
      n_checks++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rh_hold_req got %b want 0", imem_req); end
      cyc(1, 1, 32'h43, 0);
      n_checks += 3;
      if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rh_valid got %b want 0", id_valid); end
      if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rh_req got %b want 1", imem_req); end
      if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL rh_addr got %h want 40", imem_addr); end
      cyc(0, 0, 0, 1);
      n_checks += 2;
      if (id_pc4 !== 32'h44) begin n_fail++; $display("FAIL rh_pc4 got %h want 44", id_pc4); end
      if (id_ins !== mem_word(32'h40)) begin n_fail++; $display("FAIL rh_ins got %h want %h", id_ins, mem_word(32'h40)); end
   endtask

   task automatic test_reset_in_drain();
      apply_reset();
      cyc(0, 0, 0, 1);
      cyc(0, 1, 32'h80, 0);
      cyc(0, 0, 0, 0);
      n_checks++;
      if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL rdr_drain_addr got %h want 4", imem_addr); end
      rst_n = 1'b0;
      #1;
      n_checks += 4;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rdr_req got %b want 0", imem_req); end
      if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_valid got %b want 0", id_valid); end
      if (id_ins !== 32'h0) begin n_fail++; $display("FAIL rdr_ins got %h want 0", id_ins); end
      if (id_pc4 !== 32'h0) begin n_fail++; $display("FAIL rdr_pc4 got %h want 0", id_pc4); end
`ifdef IF_PERFCNT_EN
      n_checks += 2;
      if (perf_fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL rdr_perf_fetch got %0d want 0", perf_fetch_cnt); end
      if (perf_bubble_cnt !== 32'h0) begin n_fail++; $display("FAIL rdr_perf_bubble got %0d want 0", perf_bubble_cnt); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      n_checks += 2;
      if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rdr_rel_req got %b want 1", imem_req); end
      if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rdr_rel_addr got %h want 0", imem_addr); end
      cyc(0, 0, 0, 1);
      n_checks += 2;
      if (id_pc4 !== 32'h4) begin n_fail++; $display("FAIL rdr_pc4_after got %h want 4", id_pc4); end
      if (id_valid !== 1'b1) begin n_fail++; $display("FAIL rdr_valid_after got %b want 1", id_valid); end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 2) != 0);
         n_checks += 3;
         if (imem_req !== (m_q.size() == 0)) begin n_fail++; $display("FAIL rnd_req[%0d] got %b want %b", i, imem_req, m_q.size() == 0); end
         if (id_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b want %b", i, id_valid, m_valid); end
         if (id_ins !== m_ins) begin n_fail++; $display("FAIL rnd_ins[%0d] got %h want %h", i, id_ins, m_ins); end
         if (m_q.size() == 0) begin
            n_checks++;
            if (imem_addr !== m_addr) begin n_fail++; $display("FAIL rnd_addr[%0d] got %h want %h", i, imem_addr, m_addr); end
         end
         if (m_valid) begin
            n_checks++;
            if (id_pc4 !== m_pc4) begin n_fail++; $display("FAIL rnd_pc4[%0d] got %h want %h", i, id_pc4, m_pc4); end
         end
      end
`ifdef IF_PERFCNT_EN
      n_checks += 2;
      if (perf_fetch_cnt !== m_fetch_n) begin n_fail++; $display("FAIL rnd_perf_fetch got %0d want %0d", perf_fetch_cnt, m_fetch_n); end
      if (perf_bubble_cnt !== m_bubble_n) begin n_fail++; $display("FAIL rnd_perf_bubble got %0d want %0d", perf_bubble_cnt, m_bubble_n); end
`endif
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_wait_states();
      test_stall_hold();
      test_redirect_drain();
      test_redirect_in_hold();
      test_reset_in_drain();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
